upcounter_tx_sequencer: RTL and testbench
=========================================

# upcounter_tx_sequencer

Sequences the up-counter datapath and the SPI byte master so that every counter update goes out as a two-byte SPI frame: LSB first, then MSB (`{2'b00, count[13:8]}`). It owns the run/stop state and the clear pulse fed to the datapath, derived from debounced button pulses. It also drives the frame select line and reports SPI stalls and frame overruns. It sits between the button debouncers, the up-counter datapath and the SPI master.

## Interface
- `DONE_TIMEOUT`, default 4096: cycles allowed in a byte wait state before the frame is aborted (valid range 16..65535).
- `clk` in 1: system clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle count-enable strobe, the same strobe the datapath receives.
- `i_btn_runstop` in 1: one-cycle debounced pulse; toggles run/stop.
- `i_btn_clear` in 1: one-cycle debounced pulse; requests a counter clear.
- `i_spi_ready` in 1: SPI master idle and able to accept a byte.
- `i_spi_done` in 1: one-cycle pulse when the SPI master finishes a byte.
- `o_runstop` out 1: run enable to the datapath.
- `o_clear` out 1: one-cycle clear pulse to the datapath.
- `o_start_LSB` out 1: one-cycle pulse; the datapath loads `tx_data` with the LSB.
- `o_start_MSB` out 1: one-cycle pulse; the datapath loads `tx_data` with the MSB.
- `o_spi_start` out 1: one-cycle pulse; the SPI master launches the byte on `tx_data`.
- `o_ss_n` out 1: frame select, active low for the whole two-byte frame.
- `o_busy` out 1: high whenever the FSM is not in IDLE.
- `o_timeout_err` out 1: sticky; set when a frame was aborted by timeout.
- `o_overrun` out 1: sticky; set when a frame trigger was lost.

## Operation
- **Reset values:** `o_runstop`=0, `o_clear`=0, both start strobes 0, `o_spi_start`=0, `o_ss_n`=1, `o_busy`=0, both error flags 0, pending=0, FSM=IDLE.
- **Output decoding:** all outputs are decoded from registers only; there is no combinational input-to-output path.
- **Run/stop:** `o_runstop` toggles on the clock edge after each `i_btn_runstop` pulse, in any FSM state.
- **Clear:**
  - Honoured only when `o_runstop`=0; it is ignored while running.
  - When honoured: `o_clear` is high for exactly one cycle, starting the cycle after the button pulse.
  - It also clears `o_timeout_err` and `o_overrun`, and raises a frame trigger so the value 0 is transmitted.
- **Frame trigger:** `tick` && `o_runstop`, or an honoured clear.
  - `tick` is evaluated against the pre-toggle `o_runstop`, matching the datapath.
- **FSM states:**
  - IDLE: leaves on a trigger or when pending=1; clears pending on exit.
  - LATCH_L: asserts `o_start_LSB` and pulls `o_ss_n` low.
  - LOAD_L: waits for `i_spi_ready`; when it is high, pulses `o_spi_start` and moves on.
  - WAIT_L: waits for `i_spi_done`.
  - LATCH_M: asserts `o_start_MSB`.
  - LOAD_M: waits for `i_spi_ready`; when it is high, pulses `o_spi_start` and moves on.
  - WAIT_M: waits for `i_spi_done`.
  - GAP: holds `o_ss_n` high for one cycle, then goes to IDLE.
- **Frame select:** `o_ss_n` is low from LATCH_L through WAIT_M inclusive, and high in IDLE and GAP.
- **Timeout:**
  - A 16-bit wait counter resets on entering LOAD_L, WAIT_L, LOAD_M or WAIT_M.
  - It counts every cycle spent in those states.
  - On reaching `DONE_TIMEOUT-1` without progress: set `o_timeout_err`, go to GAP, and send no further byte of that frame.
- **Triggers during a frame:** a trigger while not in IDLE sets pending. If pending is already 1, `o_overrun` is set instead; pending is single-depth.
- **Stray done pulses:** `i_spi_done` outside WAIT_L/WAIT_M is ignored.
- **Stop mid-frame:** a run/stop toggle mid-frame does not abort the frame.
- **Reset mid-frame:** asserting `reset_n` mid-frame forces IDLE and `o_ss_n`=1 immediately, without waiting for a clock edge.

## Timing
- **Latch:** `tick` in cycle T → `o_start_LSB` in T+1 (the counter has already updated at the end of T).
- **LSB byte:** datapath `tx_data` holds the LSB from T+2. With `i_spi_ready`=1, `o_spi_start` is in T+2.
- **MSB byte:** `i_spi_done` in cycle D (WAIT_L) → `o_start_MSB` in D+1 → `o_spi_start` in D+2 at the earliest.
- **Frame end:** `i_spi_done` in cycle E (WAIT_M) → GAP in E+1 (`o_ss_n`=1) → IDLE in E+2. A pending frame starts at E+3.
- **Minimum frame:** 6 cycles plus two SPI byte times. This must fit within one `tick` period, otherwise pending/overrun apply.
- **Clear:** the clear-triggered frame latches the LSB two cycles after `o_clear` (counter already 0).

## Test plan
- **Normal frame:** reset, runstop pulse, then `tick` at cycle 100 with the SPI model responding `done` 20 cycles after `start` → `o_start_LSB`@101, `o_spi_start`@102, `o_start_MSB`@123, `o_spi_start`@124, `o_ss_n` low 101..144, bytes received match the counter value 1 as LSB 0x01, MSB 0x00.
- **Counter sweep:** run to count 9999 → frame bytes 0x0F, 0x27. Next tick → frame reflects the datapath wrap value.
- **Clear handling:** clear while running → no `o_clear`, no frame. Stop, then clear → `o_clear` one cycle, frame 0x00, 0x00, error flags cleared.
- **Timeout:** hold `i_spi_done` low, `DONE_TIMEOUT`=16 → abort after 16 cycles in WAIT_L, `o_timeout_err`=1, no MSB start, `o_ss_n` high in GAP.
- **Overrun:** three ticks within one frame → one pending frame sent immediately after GAP, `o_overrun`=1.
- **Reset mid-frame:** assert `reset_n` low during WAIT_M → all outputs at reset values asynchronously, a fresh frame starts cleanly after release.

Source files
------------

// File: rtl/upcounter_tx_sequencer.sv
// upcounter_tx_sequencer: frames every counter update as a two-byte SPI transfer (LSB, then MSB)
// and owns run/stop, clear, frame select and the stall/overrun flags.  Rev 1.0
`default_nettype none

module upcounter_tx_sequencer #(
   parameter int DONE_TIMEOUT = 4096
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic i_btn_runstop,
   input  logic i_btn_clear,
   input  logic i_spi_ready,
   input  logic i_spi_done,
   output logic o_runstop,
   output logic o_clear,
   output logic o_start_LSB,
   output logic o_start_MSB,
   output logic o_spi_start,
   output logic o_ss_n,
   output logic o_busy,
   output logic o_timeout_err,
   output logic o_overrun
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LATCH_L = 3'd1,
      LOAD_L  = 3'd2,
      WAIT_L  = 3'd3,
      LATCH_M = 3'd4,
      LOAD_M  = 3'd5,
      WAIT_M  = 3'd6,
      GAP     = 3'd7
   } state_t;

   localparam logic [15:0] WAIT_LIMIT = 16'(DONE_TIMEOUT - 1);

   state_t      state;
   logic        pending;
   logic        clear_d;
   logic [15:0] wait_cnt;

   logic clear_ok;
   logic trigger;
   logic timed_out;

   assign clear_ok  = i_btn_clear & ~o_runstop;
   // The clear-triggered frame is delayed so the datapath has already zeroed the counter.
   assign trigger   = (tick & o_runstop) | clear_d;
   assign timed_out = (wait_cnt == WAIT_LIMIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         pending       <= 1'b0;
         clear_d       <= 1'b0;
         wait_cnt      <= 16'd0;
         o_runstop     <= 1'b0;
         o_clear       <= 1'b0;
         o_start_LSB   <= 1'b0;
         o_start_MSB   <= 1'b0;
         o_spi_start   <= 1'b0;
         o_ss_n        <= 1'b1;
         o_busy        <= 1'b0;
         o_timeout_err <= 1'b0;
         o_overrun     <= 1'b0;
      end else begin
         o_runstop   <= o_runstop ^ i_btn_runstop;
         o_clear     <= clear_ok;
         clear_d     <= o_clear;
         o_start_LSB <= 1'b0;
         o_start_MSB <= 1'b0;
         o_spi_start <= 1'b0;

         if (state != IDLE && trigger) begin
            if (pending)
               o_overrun <= 1'b1;
            else
               pending <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (trigger || pending) begin
                  state       <= LATCH_L;
                  pending     <= 1'b0;
                  o_start_LSB <= 1'b1;
                  o_ss_n      <= 1'b0;
                  o_busy      <= 1'b1;
               end
            end
            LATCH_L: begin
               state       <= LOAD_L;
               wait_cnt    <= 16'd0;
               o_spi_start <= i_spi_ready;
            end
            LOAD_L: begin
               // o_spi_start is registered, so leave only after the pulse has been seen.
               if (o_spi_start) begin
                  state    <= WAIT_L;
                  wait_cnt <= 16'd0;
               end else if (timed_out) begin
                  state         <= GAP;
                  o_ss_n        <= 1'b1;
                  o_timeout_err <= 1'b1;
               end else begin
                  wait_cnt    <= wait_cnt + 16'd1;
                  o_spi_start <= i_spi_ready;
               end
            end
            WAIT_L: begin
               if (i_spi_done) begin
                  state       <= LATCH_M;
                  o_start_MSB <= 1'b1;
               end else if (timed_out) begin
                  state         <= GAP;
                  o_ss_n        <= 1'b1;
                  o_timeout_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            LATCH_M: begin
               state       <= LOAD_M;
               wait_cnt    <= 16'd0;
               o_spi_start <= i_spi_ready;
            end
            LOAD_M: begin
               if (o_spi_start) begin
                  state    <= WAIT_M;
                  wait_cnt <= 16'd0;
               end else if (timed_out) begin
                  state         <= GAP;
                  o_ss_n        <= 1'b1;
                  o_timeout_err <= 1'b1;
               end else begin
                  wait_cnt    <= wait_cnt + 16'd1;
                  o_spi_start <= i_spi_ready;
               end
            end
            WAIT_M: begin
               if (i_spi_done) begin
                  state  <= GAP;
                  o_ss_n <= 1'b1;
               end else if (timed_out) begin
                  state         <= GAP;
                  o_ss_n        <= 1'b1;
                  o_timeout_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            GAP: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               o_ss_n <= 1'b1;
               o_busy <= 1'b0;
            end
         endcase

         // A honoured clear wipes the error history, overriding any same-cycle set.
         if (clear_ok) begin
            o_timeout_err <= 1'b0;
            o_overrun     <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_upcounter_tx_sequencer.sv
// Bench for upcounter_tx_sequencer: datapath and SPI byte-master models around the DUT,
// directed and randomized frames checked against an arithmetic count reference.
`default_nettype none

module tb_upcounter_tx_sequencer;

   localparam int TMO = 24;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic tick = 1'b0;
   logic btn_runstop = 1'b0;
   logic btn_clear = 1'b0;
   logic spi_ready;
   logic spi_done;
   logic runstop, clear, start_lsb, start_msb, spi_start, ss_n, busy, timeout_err, overrun;

   always #5 clk = ~clk;

   upcounter_tx_sequencer #(.DONE_TIMEOUT(TMO)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .tick          (tick),
      .i_btn_runstop (btn_runstop),
      .i_btn_clear   (btn_clear),
      .i_spi_ready   (spi_ready),
      .i_spi_done    (spi_done),
      .o_runstop     (runstop),
      .o_clear       (clear),
      .o_start_LSB   (start_lsb),
      .o_start_MSB   (start_msb),
      .o_spi_start   (spi_start),
      .o_ss_n        (ss_n),
      .o_busy        (busy),
      .o_timeout_err (timeout_err),
      .o_overrun     (overrun)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Datapath: decimal 0..9999 counter and tx_data byte register
   logic [13:0] count;
   logic [7:0]  tx_data;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count   <= 14'd0;
         tx_data <= 8'd0;
      end else begin
         if (clear)
            count <= 14'd0;
         else if (tick && runstop)
            count <= (count == 14'd9999) ? 14'd0 : count + 14'd1;
         if (start_lsb)
            tx_data <= count[7:0];
         else if (start_msb)
            tx_data <= {2'b00, count[13:8]};
      end
   end

   // SPI master: done pulse spi_delay cycles after start; mute swallows bytes without done
   int         spi_delay = 20;
   bit         mute = 1'b0;
   bit         spi_busy;
   int         rem;
   logic [7:0] rx_q[$];
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spi_ready <= 1'b1;
         spi_done  <= 1'b0;
         spi_busy  <= 1'b0;
         rem       <= 0;
      end else begin
         spi_done <= 1'b0;
         if (spi_start) begin
            rx_q.push_back(tx_data);
            if (!mute) begin
               spi_busy  <= 1'b1;
               spi_ready <= 1'b0;
               rem       <= spi_delay - 1;
            end
         end else if (spi_busy) begin
            if (rem == 1) begin
               spi_done  <= 1'b1;
               spi_busy  <= 1'b0;
               spi_ready <= 1'b1;
            end else begin
               rem <= rem - 1;
            end
         end
      end
   end

   int ev_lsb[$], ev_msb[$], ev_spi[$];
   int clr_cnt = 0;
   int ss_first = -1, ss_last = -1;
   always @(negedge clk) begin
      if (start_lsb) ev_lsb.push_back(cyc);
      if (start_msb) ev_msb.push_back(cyc);
      if (spi_start) ev_spi.push_back(cyc);
      if (clear) clr_cnt++;
      if (!ss_n) begin
         if (ss_first < 0) ss_first = cyc;
         ss_last = cyc;
      end
   end

   int tests = 0;
   int fails = 0;
   int ref_val = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic clear_ev();
      ev_lsb.delete();
      ev_msb.delete();
      ev_spi.delete();
      rx_q.delete();
      ss_first = -1;
      ss_last  = -1;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic at_cycle(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic pulse_tick(output int t);
      t    = cyc;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic pulse_rs();
      btn_runstop = 1'b1;
      @(negedge clk);
      btn_runstop = 1'b0;
   endtask

   task automatic wait_quiet(input string tag, input int budget);
      int q = 0;
      int n = 0;
      while (q < 3 && n < budget) begin
         @(negedge clk);
         n++;
         if (!busy) q++; else q = 0;
      end
      check({tag, "_quiet"}, 32'(n < budget), 32'd1);
   endtask

   task automatic check_byte(input string tag, input int idx, input logic [7:0] exp);
      logic [7:0] b;
      b = (idx < rx_q.size()) ? rx_q[idx] : 8'hxx;
      check(tag, {24'd0, b}, {24'd0, exp});
   endtask

   task automatic check_frame(input string tag, input int val);
      check({tag, "_nbytes"}, rx_q.size(), 2);
      check_byte({tag, "_lsb"}, 0, 8'(val % 256));
      check_byte({tag, "_msb"}, 1, 8'(val / 256));
      rx_q.delete();
   endtask

   initial begin
      int t, c, k, d;

      // Reset state
      cycles(3);
      check("reset_outs", {23'd0, runstop, clear, start_lsb, start_msb, spi_start, ss_n, busy,
                           timeout_err, overrun}, 32'b000001000);
      reset_n = 1'b1;
      cycles(2);

      c = cyc;
      pulse_rs();
      check("runstop_on", {31'd0, runstop}, 32'd1);

      // Normal frame, SPI done 20 cycles after start
      clear_ev();
      spi_delay = 20;
      cycles(2);
      pulse_tick(t);
      ref_val = 1;
      wait_quiet("normal", 200);
      check("n_lsb_cyc", qget(ev_lsb, 0), t + 1);
      check("n_spi0_cyc", qget(ev_spi, 0), t + 2);
      check("n_msb_cyc", qget(ev_msb, 0), t + 23);
      check("n_spi1_cyc", qget(ev_spi, 1), t + 24);
      check("n_ss_first", ss_first, t + 1);
      check("n_ss_last", ss_last, t + 44);
      check_frame("normal", ref_val);

      // Counter sweep: back-to-back ticks up to 9998, then 9999 and the wrap
      tick = 1'b1;
      repeat (9997) @(negedge clk);
      tick = 1'b0;
      ref_val = (ref_val + 9997) % 10000;
      wait_quiet("burst", 400);
      clear_ev();
      pulse_tick(t);
      ref_val = (ref_val + 1) % 10000;
      wait_quiet("c9999", 200);
      check("c9999_val", ref_val, 9999);
      check_frame("c9999", ref_val);
      clear_ev();
      pulse_tick(t);
      ref_val = (ref_val + 1) % 10000;
      wait_quiet("wrap", 200);
      check_frame("wrap", ref_val);

      // Clear while running is ignored
      clear_ev();
      k = clr_cnt;
      btn_clear = 1'b1;
      @(negedge clk);
      btn_clear = 1'b0;
      cycles(6);
      check("clr_run_noclear", clr_cnt - k, 0);
      check("clr_run_noframe", ev_lsb.size(), 0);

      // Stop, then clear
      pulse_rs();
      check("runstop_off", {31'd0, runstop}, 32'd0);
      check("ovr_after_burst", {31'd0, overrun}, 32'd1);
      clear_ev();
      c = cyc;
      btn_clear = 1'b1;
      @(negedge clk);
      btn_clear = 1'b0;
      check("clear_pulse", {31'd0, clear}, 32'd1);
      check("clear_ovr", {31'd0, overrun}, 32'd0);
      @(negedge clk);
      check("clear_one_cycle", {31'd0, clear}, 32'd0);
      wait_quiet("clr", 200);
      ref_val = 0;
      check("clr_lsb_cyc", qget(ev_lsb, 0), c + 3);
      check_frame("clr", ref_val);

      // Timeout in WAIT_L: no done from the SPI master
      pulse_rs();
      mute = 1'b1;
      clear_ev();
      pulse_tick(t);
      ref_val = ref_val + 1;
      at_cycle(t + TMO + 2);
      check("to_ss_low", {31'd0, ss_n}, 32'd0);
      check("to_err_not_yet", {31'd0, timeout_err}, 32'd0);
      @(negedge clk);
      check("to_gap_ss", {31'd0, ss_n}, 32'd1);
      check("to_err", {31'd0, timeout_err}, 32'd1);
      @(negedge clk);
      check("to_idle", {31'd0, busy}, 32'd0);
      wait_quiet("to", 100);
      check("to_no_msb", ev_msb.size(), 0);
      check("to_one_byte", ev_spi.size(), 1);
      mute = 1'b0;
      clear_ev();

      // Overrun: three ticks inside one frame
      spi_delay = 10;
      pulse_tick(t);
      cycles(1);
      pulse_tick(k);
      cycles(1);
      check("ovr_not_yet", {31'd0, overrun}, 32'd0);
      pulse_tick(k);
      check("ovr_set", {31'd0, overrun}, 32'd1);
      check("ovr_terr_sticky", {31'd0, timeout_err}, 32'd1);
      wait_quiet("ovr", 300);
      check("ovr_frames", ev_lsb.size(), 2);
      check("ovr_pending_cyc", qget(ev_lsb, 1), t + 27);
      check("ovr_nbytes", rx_q.size(), 4);
      check_byte("ovr_f1_lsb", 0, 8'((ref_val + 1) % 256));
      check_byte("ovr_f2_lsb", 2, 8'((ref_val + 3) % 256));
      ref_val = ref_val + 3;
      clear_ev();

      // Randomized frames
      for (int i = 0; i < 10; i++) begin
         d = int'($urandom_range(2, 18));
         spi_delay = d;
         cycles(int'($urandom_range(1, 8)));
         clear_ev();
         pulse_tick(t);
         ref_val = (ref_val + 1) % 10000;
         wait_quiet("rnd", 200);
         check("rnd_lsb_cyc", qget(ev_lsb, 0), t + 1);
         check("rnd_msb_cyc", qget(ev_msb, 0), t + 3 + d);
         check_frame("rnd", ref_val);
      end

      // Asynchronous reset during WAIT_M
      spi_delay = 20;
      clear_ev();
      pulse_tick(t);
      at_cycle(t + 30);
      check("rm_in_frame", {31'd0, ss_n}, 32'd0);
      #2 reset_n = 1'b0;
      #1;
      check("rm_async_outs", {23'd0, runstop, clear, start_lsb, start_msb, spi_start, ss_n, busy,
                              timeout_err, overrun}, 32'b000001000);
      @(negedge clk);
      reset_n = 1'b1;
      ref_val = 0;
      clear_ev();
      cycles(2);
      pulse_rs();
      pulse_tick(t);
      ref_val = 1;
      wait_quiet("rm", 200);
      check("rm_lsb_cyc", qget(ev_lsb, 0), t + 1);
      check_frame("rm", ref_val);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
